decode: RTL

- Instruction decode stage directly downstream of instruction fetch.
- Accepts (pc, ir) beats over a valid/ready handshake and decodes RV32I fields, the format and the sign-extended immediate.
- Registers the result into one pipeline stage with its own valid/ready handshake toward execute and the register-file read ports.
- Drops in-flight work on branch or trap redirect, and flags illegal encodings for the trap logic.

---
 rtl/decode.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode.sv
// RV32I decode stage: splits fetch beats into register fields, format and immediate,
// registered once (1-cycle latency); holds outputs while execute stalls, flush drops all work.
module decode (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_ir,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_ir,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        use_rs1,
    output logic        use_rs2,
    output logic [2:0]  fmt,
    output logic [31:0] imm,
    output logic        illegal
);

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Combinational decode of the incoming word
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        dec_legal;
    fmt_e        dec_fmt;
    logic [31:0] dec_imm;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        dec_use_rs1;
    logic        dec_use_rs2;

    assign opcode = in_ir[6:0];
    assign funct3 = in_ir[14:12];
    assign funct7 = in_ir[31:25];

    always_comb begin
        dec_fmt   = FMT_NONE;
        dec_legal = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                dec_fmt   = FMT_U;
                dec_legal = 1'b1;
            end
            OP_JAL: begin
                dec_fmt   = FMT_J;
                dec_legal = 1'b1;
            end
            OP_JALR: begin
                dec_fmt   = FMT_I;
                dec_legal = (funct3 == 3'b000);
            end
            OP_LOAD: begin
                dec_fmt   = FMT_I;
                dec_legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            end
            OP_OPIMM: begin
                dec_fmt = FMT_I;
                if (funct3 == 3'b001)
                    dec_legal = (funct7 == F7_ZERO);
                else if (funct3 == 3'b101)
                    dec_legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                else
                    dec_legal = 1'b1;
            end
            OP_MISC: begin
                dec_fmt   = FMT_I;
                dec_legal = funct3 inside {3'b000, 3'b001};
            end
            OP_SYSTEM: begin
                dec_fmt   = FMT_I;
                dec_legal = (funct3 != 3'b100);
            end
            OP_STORE: begin
                dec_fmt   = FMT_S;
                dec_legal = funct3 inside {3'b000, 3'b001, 3'b010};
            end
            OP_BRANCH: begin
                dec_fmt   = FMT_B;
                dec_legal = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OP_OP: begin
                dec_fmt   = FMT_R;
                dec_legal = (funct7 == F7_ZERO) ||
                            ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            default: begin
                dec_fmt   = FMT_NONE;
                dec_legal = 1'b0;
            end
        endcase
        // Compressed-space words never reach a valid opcode match, but keep the rule explicit
        if (in_ir[1:0] != 2'b11)
            dec_legal = 1'b0;
        if (!dec_legal)
            dec_fmt = FMT_NONE;
    end

    always_comb begin
        dec_imm     = '0;
        dec_rs1     = '0;
        dec_rs2     = '0;
        dec_rd      = '0;
        dec_use_rs1 = 1'b0;
        dec_use_rs2 = 1'b0;
        case (dec_fmt)
            FMT_R: begin
                dec_rs1     = in_ir[19:15];
                dec_rs2     = in_ir[24:20];
                dec_rd      = in_ir[11:7];
                dec_use_rs1 = 1'b1;
                dec_use_rs2 = 1'b1;
            end
            FMT_I: begin
                dec_imm     = {{20{in_ir[31]}}, in_ir[31:20]};
                dec_rs1     = in_ir[19:15];
                dec_rd      = in_ir[11:7];
                dec_use_rs1 = 1'b1;
            end
            FMT_S: begin
                dec_imm     = {{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]};
                dec_rs1     = in_ir[19:15];
                dec_rs2     = in_ir[24:20];
                dec_use_rs1 = 1'b1;
                dec_use_rs2 = 1'b1;
            end
            FMT_B: begin
                dec_imm     = {{19{in_ir[31]}}, in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0};
                dec_rs1     = in_ir[19:15];
                dec_rs2     = in_ir[24:20];
                dec_use_rs1 = 1'b1;
                dec_use_rs2 = 1'b1;
            end
            FMT_U: begin
                dec_imm = {in_ir[31:12], 12'b0};
                dec_rd  = in_ir[11:7];
            end
            FMT_J: begin
                dec_imm = {{11{in_ir[31]}}, in_ir[31], in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0};
                dec_rd  = in_ir[11:7];
            end
            default: ;
        endcase
    end

    // Output pipeline register
    logic        out_valid_q, out_valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [4:0]  rs1_q, rs1_d;
    logic [4:0]  rs2_q, rs2_d;
    logic [4:0]  rd_q, rd_d;
    logic        use_rs1_q, use_rs1_d;
    logic        use_rs2_q, use_rs2_d;
    logic [2:0]  fmt_q, fmt_d;
    logic [31:0] imm_q, imm_d;
    logic        illegal_q, illegal_d;
    logic        load;

    assign in_ready = ~out_valid_q | out_ready;
    assign load     = in_valid & in_ready & ~flush;

    always_comb begin
        pc_d      = pc_q;
        ir_d      = ir_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        use_rs1_d = use_rs1_q;
        use_rs2_d = use_rs2_q;
        fmt_d     = fmt_q;
        imm_d     = imm_q;
        illegal_d = illegal_q;
        if (load) begin
            pc_d      = in_pc;
            ir_d      = in_ir;
            rs1_d     = dec_rs1;
            rs2_d     = dec_rs2;
            rd_d      = dec_rd;
            use_rs1_d = dec_use_rs1;
            use_rs2_d = dec_use_rs2;
            fmt_d     = dec_fmt;
            imm_d     = dec_imm;
            illegal_d = ~dec_legal;
        end

        if (flush)
            out_valid_d = 1'b0;
        else if (load)
            out_valid_d = 1'b1;
        else if (out_ready)
            out_valid_d = 1'b0;
        else
            out_valid_d = out_valid_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            pc_q        <= '0;
            ir_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            use_rs1_q   <= 1'b0;
            use_rs2_q   <= 1'b0;
            fmt_q       <= FMT_NONE;
            imm_q       <= '0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            use_rs1_q   <= use_rs1_d;
            use_rs2_q   <= use_rs2_d;
            fmt_q       <= fmt_d;
            imm_q       <= imm_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = pc_q;
    assign out_ir    = ir_q;
    assign rs1       = rs1_q;
    assign rs2       = rs2_q;
    assign rd        = rd_q;
    assign use_rs1   = use_rs1_q;
    assign use_rs2   = use_rs2_q;
    assign fmt       = fmt_q;
    assign imm       = imm_q;
    assign illegal   = illegal_q;

endmodule
